// File: rtl/cr_structs.sv
// cr_structs: shared stream-bus types for the TLV processor datapath.
//   axi4s_dp_bus_t : one AXI4-Stream beat including its tvalid qualifier.
package cr_structs;

    typedef struct packed {
        logic        tvalid;
        logic [63:0] tdata;
        logic [7:0]  tkeep;
        logic [3:0]  tuser;
        logic        tlast;
    } axi4s_dp_bus_t;

endpackage

// File: rtl/cr_tlvp_pkg.sv
// cr_tlvp_pkg: TLV processor egress constants and FSM state type.
package cr_tlvp_pkg;

    typedef enum logic {EGR_IDLE, EGR_FRAME} egr_state_e;

    localparam int CR_TLVP_EGR_MAX_FRAME_BEATS_DFLT = 4096;

endpackage

// File: rtl/cr_tlvp_skid2.sv
// cr_tlvp_skid2: generic 2-entry registered skid buffer.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write din into the tail entry (caller guarantees occ != 2)
//   pop        : drop the head entry (caller guarantees occ != 0)
//   occ        : number of valid entries, 0..2
//   head       : registered head entry
module cr_tlvp_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    logic [W-1:0] tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= din;
                    else             tail <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; head advances to the oldest remaining beat
                    if (occ == 2'd2) begin
                        head <= tail;
                        tail <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cr_tlvp_axi_egress.sv
// cr_tlvp_axi_egress: pops the TLV processor output FIFO into a 2-entry skid
// buffer and drives a registered AXI4-Stream master; tracks frames and flags
// frames longer than MAX_FRAME_BEATS.
//   clk, rst_n                      : clock, async active-low reset
//   tlvp_ob_empty/aempty/tlvp_ob    : show-ahead FIFO head (aempty unused)
//   tlvp_ob_rd                      : FIFO pop
//   m_axis, m_axis_tready           : AXI4-Stream master
//   frame_active                    : frame in progress on the output
//   frame_len_err, frame_len_err_clr: sticky over-length flag and its clear
//   stat_frame_cnt, stat_beat_cnt   : counters, only with CR_TLVP_AXI_EGRESS_STATS_EN
module cr_tlvp_axi_egress
    import cr_structs::*;
    import cr_tlvp_pkg::*;
#(
    parameter int MAX_FRAME_BEATS = CR_TLVP_EGR_MAX_FRAME_BEATS_DFLT,
    parameter int FLEN_W          = $clog2(MAX_FRAME_BEATS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tlvp_ob_empty,
    input  logic          tlvp_ob_aempty,
    input  axi4s_dp_bus_t tlvp_ob,
    output logic          tlvp_ob_rd,
    input  logic          m_axis_tready,
    output axi4s_dp_bus_t m_axis,
    output logic          frame_active,
    output logic          frame_len_err,
    input  logic          frame_len_err_clr
`ifdef CR_TLVP_AXI_EGRESS_STATS_EN
    ,
    output logic [31:0]   stat_frame_cnt,
    output logic [31:0]   stat_beat_cnt
`endif
);

    localparam int BW = $bits(axi4s_dp_bus_t);

    logic          rdy_q;
    logic [1:0]    occ;
    logic [BW-1:0] head;
    logic          acc;
    logic          len_viol;
    egr_state_e    state;
    logic [FLEN_W-1:0] flen;
    logic          unused_aempty;

    assign unused_aempty = tlvp_ob_aempty;

    // Read depends only on local registered state, never on tready.
    assign tlvp_ob_rd = rdy_q & ~tlvp_ob_empty & (occ != 2'd2);

    always_comb begin
        m_axis        = axi4s_dp_bus_t'(head);
        m_axis.tvalid = (occ != 2'd0);
    end

    assign acc = m_axis.tvalid & m_axis_tready;

    // Accepting another beat in FRAME when flen already holds the limit overflows it.
    assign len_viol = acc & (state == EGR_FRAME) & (flen >= FLEN_W'(MAX_FRAME_BEATS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    cr_tlvp_skid2 #(.W(BW)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tlvp_ob_rd),
        .pop   (acc),
        .din   (tlvp_ob),
        .occ   (occ),
        .head  (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EGR_IDLE;
            flen  <= '0;
        end else if (acc) begin
            case (state)
                EGR_IDLE: begin
                    if (!m_axis.tlast) begin
                        state <= EGR_FRAME;
                        flen  <= FLEN_W'(1);
                    end
                end
                EGR_FRAME: begin
                    if (m_axis.tlast) begin
                        state <= EGR_IDLE;
                        flen  <= '0;
                    end else if (flen != '1) begin
                        flen <= flen + FLEN_W'(1);
                    end
                end
                default: state <= EGR_IDLE;
            endcase
        end
    end

    assign frame_active = (state == EGR_FRAME);

    // Set has priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 frame_len_err <= 1'b0;
        else if (len_viol)          frame_len_err <= 1'b1;
        else if (frame_len_err_clr) frame_len_err <= 1'b0;
    end

`ifdef CR_TLVP_AXI_EGRESS_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frame_cnt <= '0;
            stat_beat_cnt  <= '0;
        end else if (acc) begin
            stat_beat_cnt <= stat_beat_cnt + 32'd1;
            if (m_axis.tlast) stat_frame_cnt <= stat_frame_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cr_tlvp_axi_egress.sv
// tb_cr_tlvp_axi_egress: randomized bench with an upstream FIFO model and a
// queue-based reference of beats in flight, frame length and error flag.
module tb_cr_tlvp_axi_egress;
    import cr_structs::*;

    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tlvp_ob_empty = 1'b1;
    logic          tlvp_ob_aempty = 1'b1;
    axi4s_dp_bus_t tlvp_ob = '0;
    logic          tlvp_ob_rd;
    logic          m_axis_tready = 1'b0;
    axi4s_dp_bus_t m_axis;
    logic          frame_active;
    logic          frame_len_err;
    logic          frame_len_err_clr = 1'b0;
`ifdef CR_TLVP_AXI_EGRESS_STATS_EN
    logic [31:0]   stat_frame_cnt;
    logic [31:0]   stat_beat_cnt;
`endif

    cr_tlvp_axi_egress #(.MAX_FRAME_BEATS(MAXB)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .tlvp_ob_empty     (tlvp_ob_empty),
        .tlvp_ob_aempty    (tlvp_ob_aempty),
        .tlvp_ob           (tlvp_ob),
        .tlvp_ob_rd        (tlvp_ob_rd),
        .m_axis_tready     (m_axis_tready),
        .m_axis            (m_axis),
        .frame_active      (frame_active),
        .frame_len_err     (frame_len_err),
        .frame_len_err_clr (frame_len_err_clr)
`ifdef CR_TLVP_AXI_EGRESS_STATS_EN
        ,
        .stat_frame_cnt    (stat_frame_cnt),
        .stat_beat_cnt     (stat_beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    axi4s_dp_bus_t up[$];   // upstream FIFO contents
    axi4s_dp_bus_t sb[$];   // beats popped but not yet accepted downstream
    int          cnt;       // beats accepted in the current multi-beat frame, 0 = idle
    bit          err_m, rdy_m, gap;
    int unsigned beats_m, frames_m;
    int          pass_n, chk_n;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_n++;
        if (got === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [76:0] pay(input axi4s_dp_bus_t b);
        return {b.tdata, b.tkeep, b.tuser, b.tlast};
    endfunction

    task automatic add_frame(input int len);
        axi4s_dp_bus_t b;
        for (int i = 0; i < len; i++) begin
            b.tvalid = 1'b1;
            b.tdata  = {$urandom, $urandom};
            b.tkeep  = 8'($urandom);
            b.tuser  = 4'($urandom);
            b.tlast  = (i == len - 1);
            up.push_back(b);
        end
    endtask

    // One clock: called and returns at a negedge. clr_mode: 0 none, 1 pulse,
    // 2 pulse only together with a predicted over-length acceptance, 3 random.
    task automatic cycle(input bit tr, input int clr_mode);
        bit acc, rd, clr, viol;
        axi4s_dp_bus_t e;
        m_axis_tready = tr;
        tlvp_ob_empty = (up.size() == 0) || gap;
        tlvp_ob       = tlvp_ob_empty ? '0 : up[0];
        #1;
        chk("rd", 128'(tlvp_ob_rd), 128'(rdy_m && !tlvp_ob_empty && sb.size() < 2));
        chk("tvalid", 128'(m_axis.tvalid), 128'(sb.size() != 0));
        if (sb.size() != 0) chk("data", 128'(pay(m_axis)), 128'(pay(sb[0])));
        acc  = (sb.size() != 0) && tr;
        rd   = tlvp_ob_rd && !tlvp_ob_empty;
        viol = acc && cnt > 0 && cnt + 1 > MAXB;
        clr  = (clr_mode == 1) || (clr_mode == 2 && viol) ||
               (clr_mode == 3 && $urandom_range(0, 7) == 0);
        frame_len_err_clr = clr;
        @(posedge clk);
        if (acc) begin
            e = sb.pop_front();
            beats_m++;
            if (e.tlast) frames_m++;
            if (cnt == 0) cnt = e.tlast ? 0 : 1;
            else          cnt = e.tlast ? 0 : cnt + 1;
        end
        if (rd) sb.push_back(up.pop_front());
        if (viol)     err_m = 1'b1;
        else if (clr) err_m = 1'b0;
        rdy_m = 1'b1;
        @(negedge clk);
        frame_len_err_clr = 1'b0;
        chk("frame_active", 128'(frame_active), 128'(cnt > 0));
        chk("frame_len_err", 128'(frame_len_err), 128'(err_m));
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (up.size() != 0 || sb.size() != 0); i++) cycle(1'b1, 0);
        chk("drain_left", 128'(up.size() + sb.size()), 128'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_tvalid", 128'(m_axis.tvalid), 128'(0));
        chk("rst_m_axis", 128'(m_axis), 128'(0));
        chk("rst_rd", 128'(tlvp_ob_rd), 128'(0));
        chk("rst_active", 128'(frame_active), 128'(0));
        chk("rst_err", 128'(frame_len_err), 128'(0));
`ifdef CR_TLVP_AXI_EGRESS_STATS_EN
        chk("rst_stat_beats", 128'(stat_beat_cnt), 128'(0));
        chk("rst_stat_frames", 128'(stat_frame_cnt), 128'(0));
`endif
        sb.delete();
        cnt = 0; err_m = 0; rdy_m = 0; beats_m = 0; frames_m = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        pass_n = 0; chk_n = 0; gap = 0;
        do_reset();

        // streaming: 8-beat frame, tready held high (over the limit of 4)
        add_frame(8);
        drain();

        // clear the flag, then a 6-beat frame with clear coinciding with violations
        cycle(1'b1, 1);
        add_frame(6);
        for (int i = 0; i < 40 && (up.size() != 0 || sb.size() != 0); i++) cycle(1'b1, 2);
        chk("err_after_clr_race", 128'(frame_len_err), 128'(1));
        cycle(1'b1, 1);

        // back-pressure: 5 stalled cycles mid-stream
        add_frame(10);
        for (int i = 0; i < 3; i++) cycle(1'b1, 0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 0);
        drain();

        // single-beat frames back to back
        do_reset();
        for (int i = 0; i < 10; i++) add_frame(1);
        drain();
`ifdef CR_TLVP_AXI_EGRESS_STATS_EN
        chk("stat_frames_single", 128'(stat_frame_cnt), 128'(10));
        chk("stat_beats_single", 128'(stat_beat_cnt), 128'(10));
`endif

        // randomized traffic, gaps, back-pressure and clears
        for (int i = 0; i < 400; i++) begin
            if (up.size() < 4 && $urandom_range(0, 2) == 0) add_frame($urandom_range(1, 7));
            gap = ($urandom_range(0, 3) == 0);
            cycle($urandom_range(0, 3) != 0, 3);
        end
        gap = 0;
        drain();
`ifdef CR_TLVP_AXI_EGRESS_STATS_EN
        chk("stat_frames_rand", 128'(stat_frame_cnt), 128'(frames_m));
        chk("stat_beats_rand", 128'(stat_beat_cnt), 128'(beats_m));
`endif

        // reset mid-frame with the buffer full
        add_frame(6);
        cycle(1'b1, 0);
        cycle(1'b1, 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 0);
        chk("pre_rst_active", 128'(frame_active), 128'(1));
        do_reset();
        up.delete();
        add_frame(3);
        drain();
        add_frame(5);
        drain();

        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

endmodule

// File: doc/cr_tlvp_axi_egress.md
# cr_tlvp_axi_egress

Egress stage placed directly downstream of the TLV processor's output FIFO. It pops show-ahead `axi4s_dp_bus_t` beats using the `tlvp_ob_empty`/`tlvp_ob_rd` handshake and re-times them through a 2-entry skid buffer. It presents them as an AXI4-Stream master with registered outputs, so no path runs from `m_axis_tready` to `tlvp_ob_rd`. It also tracks frame boundaries and flags frames whose beat count exceeds a limit.

## Interface
Parameters:
- `MAX_FRAME_BEATS`, default 4096: beat limit per frame; must be ≥ 2.
- `FLEN_W`, default `$clog2(MAX_FRAME_BEATS+1)`: width of the frame beat counter.

Ports (each line: name, direction, width, meaning):
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `tlvp_ob_empty`, in, 1: upstream FIFO empty.
- `tlvp_ob_aempty`, in, 1: upstream almost-empty; informational only, unused.
- `tlvp_ob`, in, `axi4s_dp_bus_t`: show-ahead head beat, valid when `!tlvp_ob_empty`.
- `tlvp_ob_rd`, out, 1: pops the head beat in the cycle it is asserted.
- `m_axis_tready`, in, 1: downstream ready.
- `m_axis`, out, `axi4s_dp_bus_t`: output beat; `m_axis.tvalid` is the valid.
- `frame_active`, out, 1: a frame is in progress on the output.
- `frame_len_err`, out, 1: sticky flag for a frame exceeding the beat limit.
- `frame_len_err_clr`, in, 1: clears `frame_len_err`; a single-cycle pulse.
- `stat_frame_cnt`, out, 32: frame counter; present only under `CR_TLVP_AXI_EGRESS_STATS_EN`.
- `stat_beat_cnt`, out, 32: beat counter; present only under `CR_TLVP_AXI_EGRESS_STATS_EN`.

## Operation
- **Skid buffer.** Two entries, tracked by `occ` ∈ {0,1,2}. The head entry drives `m_axis`; all fields are registered.
- **Read rule.** `tlvp_ob_rd = rdy_q & !tlvp_ob_empty & (occ != 2)`. There is no `tready` term.
  - `rdy_q` is reset to 0 and set to 1 on the first clock after reset.
- **Push and pop.**
  - Push: the popped beat is written to the tail entry on the same edge.
  - Pop: occurs on `m_axis.tvalid & m_axis_tready`.
  - Simultaneous push and pop leaves `occ` unchanged, with the head advancing to the tail or the new beat.
- **Output data.** `m_axis.tvalid = (occ != 0)`. The `m_axis` fields hold stable while `tvalid & !tready`.
- **Frame FSM.** Advances only on accepted output beats ("acc" = `tvalid & tready`).
  - IDLE, acc with `!tlast`: go to FRAME, `flen` = 1.
  - IDLE, acc with `tlast`: single-beat frame; stay in IDLE.
  - FRAME, acc with `!tlast`: `flen` += 1, saturating at all-ones.
  - FRAME, acc with `tlast`: return to IDLE, `flen` = 0.
- **Length error.**
  - `frame_len_err` sets when an acc in FRAME (including the `tlast` beat) makes the beat count exceed `MAX_FRAME_BEATS`.
  - Data continues to pass unmodified; the frame still ends on `tlast`.
- **Clearing the error.** `frame_len_err_clr` clears the flag. If a set and a clear occur in the same cycle, set wins.
- **Frame indicator.** `frame_active = (state == FRAME)`.

## Timing
- **Latency.** A beat popped at edge N is on `m_axis` after edge N, with `tvalid` high in cycle N+1.
- **Throughput.** One beat per cycle is sustained with `tready` held at 1 (`occ` stays at 1).
- **Back-pressure.** `tready` = 0 fills the buffer to `occ` = 2, after which `tlvp_ob_rd` drops in the following cycle. No beat is lost or duplicated.
- **Reset values.**
  - `m_axis` all fields = 0, `tvalid` = 0.
  - `occ` = 0, FSM state = IDLE, `flen` = 0.
  - `frame_active` = 0, `frame_len_err` = 0.
  - `tlvp_ob_rd` = 0 until `rdy_q` is set.
  - Stats counters = 0.
- **Reset mid-frame.** Buffered beats are discarded and the FSM returns to IDLE. There is no partial-frame recovery.
- **Empty upstream.** With `tlvp_ob_empty` = 1, `tlvp_ob_rd` = 0 regardless of `occ`.

## Configuration
- `CR_TLVP_AXI_EGRESS_STATS_EN` defined:
  - `stat_beat_cnt` increments on every acc.
  - `stat_frame_cnt` increments on every acc with `tlast`.
  - Both are 32 bits, wrap modulo 2^32, and are cleared only by reset.
- Macro undefined: the two stat ports and their counters are absent. All other behaviour is identical.

## Structure
- The shared package `cr_tlvp_pkg` holds:
  - `typedef enum logic {EGR_IDLE, EGR_FRAME} egr_state_e`;
  - the constant `CR_TLVP_EGR_MAX_FRAME_BEATS_DFLT = 4096`.
- `axi4s_dp_bus_t` comes from `cr_structs`.
- The sub-module `cr_tlvp_skid2` is the generic 2-entry registered skid buffer: push, pop, `occ`, head data. The top level holds the FSM, the length check and the stats.

## Test plan
- **Streaming.** Upstream holds 8 beats (frame of 8, `tlast` on beat 8), `tready` = 1. Expect `rd` asserted for 8 consecutive cycles, `m_axis` beats in order one cycle later, `frame_active` high from beat 1 to beat 8 acceptance, then low.
- **Back-pressure.** `tready` = 0 for 5 cycles mid-stream. Expect `occ` to reach 2, `rd` = 0 after that, `m_axis` data stable, and no loss or duplicate after `tready` returns to 1 (compared beat-for-beat against a scoreboard).
- **Frame length error.** `MAX_FRAME_BEATS` = 4, frame of 6 beats. Expect `frame_len_err` = 1 after the 5th acc, data unchanged, FSM back to IDLE after beat 6. Then assert `frame_len_err_clr` in the same cycle as a new violation: the flag stays 1.
- **Single-beat frames.** Back-to-back `tlast`-only beats. Expect `frame_active` to stay 0, and `stat_frame_cnt` = `stat_beat_cnt` = 10 after 10 beats (STATS_EN build).
- **Reset mid-frame.** Assert `rst_n` = 0 with `occ` = 2 in FRAME. Expect `tvalid` = 0 immediately (asynchronously), `rd` = 0 in the first post-reset cycle, and a fresh frame afterwards processed correctly.
